instruction_prefetch_unit: RTL
==============================

# instruction_prefetch_unit

Fetch-side initiator for the instruction memory. It owns the fetch PC and drives the word address to the combinational-read instruction memory each cycle. It captures each returned word with its PC into a small prefetch FIFO and hands entries to decode over a valid/ready handshake. Control-flow redirects (taken branch, JAL, JALR) flush the FIFO and restart fetch at the target.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- FIFO_DEPTH, 4, prefetch entries; power of two, ≥2.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- fetch_enable  in  1  permits new fetches; low holds fetch_pc and does not block popping.
- imem_pc  out  32  byte address to the instruction memory; equals fetch_pc.
- imem_instruction  in  32  same-cycle read data for imem_pc.
- redirect_valid  in  1  one-cycle pulse requesting a control-flow redirect.
- redirect_pc  in  32  redirect target.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode accepts the head.
- inst_out  out  32  head instruction; 0 when empty.
- inst_pc  out  32  head PC; 0 when empty.
- misaligned_fault  out  1  sticky fault flag.
- fault_pc  out  32  offending redirect target.

## Operation
- States: FETCH, HOLD, FAULT.
  - FETCH: a push occurs this cycle.
  - HOLD: fetch_enable=0 or no space.
  - FAULT: macro only.
- Push condition: state≠FAULT, fetch_enable=1, no redirect, and (count<FIFO_DEPTH or pop this cycle).
- On push: {fetch_pc, imem_instruction} is written at the edge and fetch_pc advances by 4.
- fetch_pc wraps modulo 2^32 (FFFF_FFFC → 0000_0000).
- Pop condition: inst_valid & inst_ready.
- Push and pop in the same cycle leave the count unchanged.
- inst_valid = (count≠0).
- Redirect has priority over push and pop:
  - A handshake completing in the redirect cycle is honoured, since decode consumed it.
  - At the edge, count←0 and fetch_pc←redirect_pc.
  - No push occurs in the redirect cycle.
- Memory contents are not interpreted; out-of-range zeros pass through as data.
- Reset values:
  - fetch_pc=imem_pc=RESET_PC; count=0; inst_valid=0; inst_out=0; inst_pc=0.
  - misaligned_fault=0; fault_pc=0; state=FETCH.
- Asserting reset mid-stream discards all entries immediately, because reset is asynchronous.

## Timing
- Fetch-to-output latency is 1 cycle: a word pushed at edge N is visible on inst_* after edge N.
- Steady-state throughput is one instruction per cycle when inst_ready=1.
- Redirect penalty:
  - inst_valid=0 in the cycle after the redirect edge.
  - The target instruction appears one cycle later.
- When full and stalled, imem_pc holds steady until space frees.
- The head entry is stable while inst_valid=1 and inst_ready=0.

## Configuration
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0]≠0 flushes the FIFO and enters FAULT.
  - It sets misaligned_fault=1 and fault_pc=redirect_pc.
  - In FAULT, no fetching occurs and inst_valid stays 0.
  - The next aligned redirect clears the fault and resumes fetch at its target.
  - Reset also clears the fault.
- Undefined:
  - redirect_pc[1:0] is forced to 00.
  - misaligned_fault is tied to 0 and fault_pc to 0; the ports remain present.

## Structure
- Shared header modules/headers/fetch.vh holds:
  - state encodings FETCH_STATE_FETCH/HOLD/FAULT;
  - PC_STEP = 4;
  - the entry width, 64 bits = {pc, instruction}.
- One sub-module, fetch_fifo: a synchronous FIFO parameterised by depth and width.
  - It provides push, pop, flush, count, and head outputs.
  - Flush takes priority over push.

## Test plan
- Reset with RESET_PC=0 and inst_ready=1 → first handshake inst_pc=0, inst_out=32'h2BC00093; next inst_pc=4, inst_out=32'h01809113; one instruction per cycle, no gaps.
- inst_ready=0 for 10 cycles, FIFO_DEPTH=4 → count saturates at 4 and imem_pc holds 32'h10; on release, PCs 0,4,8,C,10 arrive in order with no duplicates.
- Redirect to 32'h78 with 3 entries queued → inst_valid=0 next cycle; following cycle inst_pc=32'h78; the queued entries are never presented.
- Redirect and handshake in the same cycle → the popped entry counts as delivered exactly once; the next presented PC is the target.
- RESET_PC=32'hFFFF_FFF8 → PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; then assert reset mid-stream → inst_valid=0 immediately, restart at RESET_PC.
- With FETCH_MISALIGN_TRAP_EN, redirect 32'h22 → misaligned_fault=1, fault_pc=32'h22, inst_valid=0 held; redirect 32'h40 → fault clears, inst_pc=32'h40. Without the macro, the same stimulus fetches from 32'h20.

Source files
------------

// File: rtl/instruction_prefetch_unit_pkg.sv
// Shared fetch-side types: FSM state encodings, PC stride and the {pc, instruction} FIFO entry.
package instruction_prefetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_STATE_FETCH = 2'd0,
        FETCH_STATE_HOLD  = 2'd1,
        FETCH_STATE_FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;
    localparam int          ENTRY_W = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_prefetch_unit_fetch_fifo.sv
// Synchronous prefetch FIFO with flush; flush wins over a same-cycle push.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [PW:0]      cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PW'(1);
            if (pop_i)  rd_q <= rd_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage carries no reset; the head is qualified by count downstream.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Fetch PC owner and prefetch queue feeding decode; redirects flush and restart fetch.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets trap into a sticky FAULT state.
module instruction_prefetch_unit
    import instruction_prefetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_enable,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        misaligned_fault,
    output logic [31:0] fault_pc
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  state_q;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   target;
    logic [CW-1:0] count;
    fetch_entry_t  head, wentry;
    logic          push, pop, space, faulted, redir_mis;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fault_q;
    logic [31:0] fault_pc_q;
    assign target           = redirect_pc;
    assign redir_mis        = |redirect_pc[1:0];
    assign faulted          = (state_q == FETCH_STATE_FAULT);
    assign misaligned_fault = fault_q;
    assign fault_pc         = fault_pc_q;
`else
    assign target           = redirect_pc & ~32'h3;
    assign redir_mis        = 1'b0;
    assign faulted          = 1'b0;
    assign misaligned_fault = 1'b0;
    assign fault_pc         = 32'h0;
`endif

    assign inst_valid = (count != '0);
    assign pop        = inst_valid & inst_ready;
    assign space      = (count < CW'(FIFO_DEPTH));
    // A pop frees a slot in the same cycle, so a full queue still streams.
    assign push       = !faulted & fetch_enable & !redirect_valid & (space | pop);
    assign wentry     = '{pc: fetch_pc_q, instr: imem_instruction};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) fetch_pc_d = target;
        else if (push)      fetch_pc_d = fetch_pc_q + PC_STEP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH_STATE_FETCH;
            fetch_pc_q <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
`endif
        end else begin
            fetch_pc_q <= fetch_pc_d;
            if (redirect_valid) begin
                state_q <= redir_mis ? FETCH_STATE_FAULT : FETCH_STATE_HOLD;
`ifdef FETCH_MISALIGN_TRAP_EN
                fault_q <= redir_mis;
                if (redir_mis) fault_pc_q <= target;
`endif
            end else if (push) begin
                state_q <= FETCH_STATE_FETCH;
            end else if (!faulted) begin
                state_q <= FETCH_STATE_HOLD;
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (wentry),
        .count_o (count),
        .head_o  (head)
    );

    assign imem_pc  = fetch_pc_q;
    assign inst_out = inst_valid ? head.instr : 32'h0;
    assign inst_pc  = inst_valid ? head.pc    : 32'h0;

endmodule
